// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one byte with odd parity, checks the ACK bit.
// Optional transfer watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error,
  input  logic       clk_kb_in,
  input  logic       data_kb_in,
  output logic       clk_kb_drive_low,
  output logic       data_kb_drive_low
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE, S_DONE
  } state_t;

  localparam int ICW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [ICW-1:0] INH_LAST = ICW'(INHIBIT_CYCLES - 1);

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);
  logic [TCW-1:0] to_cnt, to_cnt_d;
`endif

  state_t         state, state_d;
  logic [ICW-1:0] inh_cnt, inh_cnt_d;
  logic [3:0]     bit_cnt, bit_cnt_d;
  logic [9:0]     shreg, shreg_d;
  logic           ack_ok, ack_ok_d;
  logic           error, error_d;

  logic [1:0] clk_sync, data_sync;
  logic       clk_prev;
  logic       clk_s, data_s, fall;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall   = clk_prev & ~clk_s;

  // Lines idle high, so synchronizers reset to 1 to avoid a false falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a true shift chain.
      clk_sync  <= {clk_sync[0], clk_kb_in};
      data_sync <= {data_sync[0], data_kb_in};
      clk_prev  <= clk_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      inh_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '1;
      ack_ok  <= 1'b0;
      error   <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      to_cnt  <= '0;
`endif
    end else begin
      state   <= state_d;
      inh_cnt <= inh_cnt_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
      ack_ok  <= ack_ok_d;
      error   <= error_d;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      to_cnt  <= to_cnt_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every target gets a hold default first so no path leaves it unassigned (no latch).
    state_d   = state;
    inh_cnt_d = inh_cnt;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    ack_ok_d  = ack_ok;
    error_d   = error;
`ifdef PS2_HOST_TX_TIMEOUT_EN
    to_cnt_d  = to_cnt;
`endif

    unique case (state)
      S_IDLE: begin
        if (tx_start) begin
          // Frame after the start bit: data LSB first, odd parity, stop.
          shreg_d   = {1'b1, ~^tx_data, tx_data};
          ack_ok_d  = 1'b0;
          error_d   = 1'b0;
          inh_cnt_d = '0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          bit_cnt_d = '0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
          state_d   = S_REQ;
        end else begin
          inh_cnt_d = inh_cnt + ICW'(1);
        end
      end
      S_REQ: begin
        if (fall) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (fall) begin
          if (bit_cnt == 4'd9) begin
            ack_ok_d = ~data_s;
            error_d  = data_s;
            state_d  = S_ACK;
          end else begin
            shreg_d   = {1'b1, shreg[9:1]};
            bit_cnt_d = bit_cnt + 4'd1;
          end
        end
      end
      S_ACK:       state_d = S_WAIT_IDLE;
      S_WAIT_IDLE: if (clk_s && data_s) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
    if (state == S_REQ || state == S_SHIFT || state == S_ACK) begin
      if (to_cnt == TO_LAST) begin
        ack_ok_d = 1'b0;
        error_d  = 1'b1;
        state_d  = S_DONE;
      end else begin
        to_cnt_d = to_cnt + TCW'(1);
      end
    end
`endif
  end

  assign clk_kb_drive_low  = (state == S_INHIBIT);
  assign data_kb_drive_low = (state == S_INHIBIT && inh_cnt == INH_LAST) ||
                             (state == S_REQ) ||
                             (state == S_SHIFT && !shreg[0]);
  assign tx_busy   = (state != S_IDLE);
  assign tx_done   = (state == S_DONE);
  assign tx_ack_ok = ack_ok;
  assign tx_error  = error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// compares them with frames built from the byte by counting ones.
module tb_ps2_host_tx;

  localparam int INH = 5000;
  localparam int TO  = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_ack_ok, tx_error;
  logic       clk_kb_drive_low, data_kb_drive_low;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       clk_kb_in, data_kb_in;

  // Open-drain bus with pull-ups: either side can pull a line low.
  assign clk_kb_in  = dev_clk & ~clk_kb_drive_low;
  assign data_kb_in = dev_data & ~data_kb_drive_low;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_ack_ok(tx_ack_ok), .tx_error(tx_error),
    .clk_kb_in(clk_kb_in), .data_kb_in(data_kb_in),
    .clk_kb_drive_low(clk_kb_drive_low), .data_kb_drive_low(data_kb_drive_low)
  );

  always #5 clk = ~clk;

  int   tests = 0, fails = 0;
  int   started = 0, done_seen = 0, aborted = 0;
  logic exp_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bits after the start bit: data LSB first, parity making the ones count odd, stop = 1.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int   ones = 0;
    logic par;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par = ((ones % 2) == 0);
    return {1'b1, par, d};
  endfunction

  // Per-cycle output monitor.
  initial begin
    int   run = 0, dl_cnt = 0;
    logic prev_cd = 1'b0, last_dl = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        run = 0; dl_cnt = 0; prev_cd = 1'b0;
        continue;
      end
      if (started > done_seen + aborted) begin
        check("busy_during_transfer", tx_busy, 1);
        if (tx_done) begin
          check("ack_ok_at_done", tx_ack_ok, exp_ack);
          check("error_at_done", tx_error, !exp_ack);
          check("lines_released_at_done", {clk_kb_drive_low, data_kb_drive_low}, 0);
          done_seen++;
        end
      end else begin
        check("idle_outputs", {tx_busy, tx_done, clk_kb_drive_low, data_kb_drive_low}, 0);
      end
      if (clk_kb_drive_low) begin
        run++;
        if (data_kb_drive_low) dl_cnt++;
        last_dl = data_kb_drive_low;
      end else if (prev_cd) begin
        check("inhibit_length", run, INH);
        check("inhibit_data_low_cycles", dl_cnt, 1);
        check("inhibit_last_cycle_data_low", last_dl, 1);
        run = 0; dl_cnt = 0;
      end
      prev_cd = clk_kb_drive_low;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic start_tx(input logic [7:0] d, input logic ack);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    exp_ack  = ack;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    started++;
  endtask

  // Device side: waits out the inhibit, then produces n_edges clock pulses.
  // With n_edges < 11 it returns with the clock still held low.
  task automatic device(input logic [7:0] d, input logic ack, input int half,
                        input int n_edges, output logic [9:0] frame);
    logic [9:0] exp_f;
    int guard;
    exp_f = model_frame(d);
    frame = '1;
    guard = 0;
    while (!clk_kb_drive_low && guard < 100) begin @(negedge clk); guard++; end
    check("inhibit_seen", clk_kb_drive_low, 1);
    guard = 0;
    while (clk_kb_drive_low && guard < INH + 100) begin @(negedge clk); guard++; end
    check("inhibit_released", clk_kb_drive_low, 0);
    repeat (4) @(negedge clk);
    check("start_bit", data_kb_in, 0);
    for (int k = 1; k <= n_edges; k++) begin
      dev_clk = 1'b0;
      repeat (3) @(negedge clk);
      if (k <= 10) check($sformatf("bit%0d_latency", k - 1), data_kb_drive_low, !exp_f[k - 1]);
      if (k == n_edges && n_edges < 11) return;
      repeat (half - 3) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) frame[k - 1] = data_kb_in;
      if (k == 10 && ack) dev_data = 1'b0;
      repeat (half) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic run_tx(input logic [7:0] d, input logic ack, input int half,
                        input logic inject, output logic [9:0] frame);
    int d0, n;
    d0 = done_seen;
    start_tx(d, ack);
    fork
      device(d, ack, half, 11, frame);
      if (inject) begin
        repeat (9) @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    n = 0;
    while (done_seen == d0 && n < 50) begin @(negedge clk); n++; end
    check("frame_vs_model", frame, model_frame(d));
    repeat (5) @(negedge clk);
    check("exactly_one_done", done_seen - d0, 1);
    check("ack_ok_held", tx_ack_ok, ack);
    check("error_held", tx_error, !ack);
  endtask

  initial begin
    logic [9:0] f;
    int d0, n;
    repeat (3) @(negedge clk);
    check("reset_outputs", {tx_busy, tx_done, tx_ack_ok, tx_error, clk_kb_drive_low, data_kb_drive_low}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Device clock edges while idle must be ignored.
    for (int i = 0; i < 6; i++) begin
      dev_clk = 1'b0; repeat (10) @(negedge clk);
      dev_clk = 1'b1; repeat (10) @(negedge clk);
    end
    check("idle_edges_no_busy", {tx_busy, clk_kb_drive_low, data_kb_drive_low}, 0);

    run_tx(8'hED, 1'b1, 30, 1'b0, f);
    check("ed_bits_literal", f[7:0], 8'hED);
    check("ed_parity_literal", f[8], 1);
    check("ed_stop_literal", f[9], 1);

    run_tx(8'hF4, 1'b0, 25, 1'b0, f);
    check("f4_parity_literal", f[8], 0);
    check("f4_error_literal", {tx_ack_ok, tx_error}, 2'b01);

    run_tx(8'hED, 1'b1, 20, 1'b1, f);
    check("ed_ignored_start_bits", f[7:0], 8'hED);

    // Reset while data bit 4 is on the line.
    start_tx(8'h5A, 1'b1);
    device(8'h5A, 1'b1, 20, 5, f);
    d0 = done_seen;
    @(negedge clk);
    rst = 1'b1;
    aborted++;
    #1;
    check("reset_mid_transfer", {clk_kb_drive_low, data_kb_drive_low, tx_busy, tx_done}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    dev_clk = 1'b1;
    repeat (200) @(negedge clk);
    check("no_done_after_reset", done_seen - d0, 0);

    run_tx(8'hFF, 1'b1, 25, 1'b0, f);
    check("ff_parity_literal", f[8], 1);

    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      logic a;
      d = 8'($urandom);
      a = 1'($urandom_range(0, 1));
      run_tx(d, a, $urandom_range(12, 40), 1'b0, f);
    end

`ifdef PS2_HOST_TX_TIMEOUT_EN
    // Device never clocks: transfer must end TO cycles after REQ entry.
    start_tx(8'h3C, 1'b0);
    n = 0;
    while (!clk_kb_drive_low && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (clk_kb_drive_low && n < INH + 100) begin @(negedge clk); n++; end
    n = 0;
    while (!tx_done && n < TO + 100) begin @(negedge clk); n++; end
    check("timeout_cycles", n, TO);
    check("timeout_flags", {tx_ack_ok, tx_error}, 2'b01);
    check("timeout_lines", {clk_kb_drive_low, data_kb_drive_low}, 0);
    repeat (5) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
